// File: rtl/sipo_rx_ctrl_if.sv
// Handshake and status bundle between the SIPO receive controller and its
// serial source / parallel consumer.
interface sipo_rx_ctrl_if #(
   parameter int WIDTH = 4
) ();
   localparam int CNT_W = $clog2(WIDTH);

   logic             start;
   logic             abort;
   logic             sin;
   logic             sin_valid;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;

   // Side that supplies the serial stream and consumes the parallel words
   modport master (
      output start, abort, sin, sin_valid, dout_ready,
      input  dout, dout_valid, busy, bit_cnt, overrun
   );

   // The receive controller itself
   modport slave (
      input  start, abort, sin, sin_valid, dout_ready,
      output dout, dout_valid, busy, bit_cnt, overrun
   );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out receive controller: frames sin into WIDTH-bit words,
// hands each word downstream with valid/ready and flags words lost to back-pressure.
module sipo_rx_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input logic           clk,
   input logic           rst,
   sipo_rx_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] sr_r, sr_nxt_s, shifted_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] dout_r, dout_nxt_s;
   logic             dv_r, dv_nxt_s;
   logic             ovr_r, ovr_nxt_s;
   logic             busy_r;
   logic             complete_s;
   logic             xfer_s;

   // Shift-register image after taking sin, in the configured bit order
   always_comb begin
      if (LSB_FIRST) begin
         shifted_s = {bus.sin, sr_r[WIDTH-1:1]};
      end else begin
         shifted_s = {sr_r[WIDTH-2:0], bus.sin};
      end
   end

   assign xfer_s = dv_r & bus.dout_ready;

   // Framing FSM next state plus shift/count/output-register next values
   always_comb begin
      state_nxt_s = state_r;
      sr_nxt_s    = sr_r;
      cnt_nxt_s   = cnt_r;
      ovr_nxt_s   = ovr_r;
      dout_nxt_s  = dout_r;
      dv_nxt_s    = dv_r;
      complete_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_SHIFT;
               sr_nxt_s    = {WIDTH{1'b0}};
               cnt_nxt_s   = CNT_ZERO;
               ovr_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // abort outranks start; both drop the partial word and mask sin_valid
            if (bus.abort) begin
               state_nxt_s = ST_IDLE;
               sr_nxt_s    = {WIDTH{1'b0}};
               cnt_nxt_s   = CNT_ZERO;
            end else if (bus.start) begin
               sr_nxt_s  = {WIDTH{1'b0}};
               cnt_nxt_s = CNT_ZERO;
               ovr_nxt_s = 1'b0;
            end else if (bus.sin_valid) begin
               sr_nxt_s = shifted_s;
               if (cnt_r == CNT_LAST) begin
                  complete_s = 1'b1;
                  cnt_nxt_s  = CNT_ZERO;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end else begin
               sr_nxt_s = sr_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            sr_nxt_s    = {WIDTH{1'b0}};
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase

      // A completed word is accepted only if the output slot is free or draining now
      if (complete_s) begin
         if (!dv_r || xfer_s) begin
            dout_nxt_s = shifted_s;
            dv_nxt_s   = 1'b1;
         end else begin
            ovr_nxt_s = 1'b1;
         end
      end else if (xfer_s) begin
         dv_nxt_s = 1'b0;
      end else begin
         dv_nxt_s = dv_r;
      end
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         sr_r    <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         dout_r  <= {WIDTH{1'b0}};
         dv_r    <= 1'b0;
         ovr_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         sr_r    <= sr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         dout_r  <= dout_nxt_s;
         dv_r    <= dv_nxt_s;
         ovr_r   <= ovr_nxt_s;
         busy_r  <= (state_nxt_s == ST_SHIFT);
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dv_r;
   assign bus.busy       = busy_r;
   assign bus.bit_cnt    = cnt_r;
   assign bus.overrun    = ovr_r;

   sipo_rx_ctrl_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .dout       (dout_r),
      .dout_valid (dv_r),
      .dout_ready (bus.dout_ready),
      .busy       (busy_r),
      .bit_cnt    (cnt_r)
   );
endmodule

// Protocol properties of the receive controller outputs.
module sipo_rx_ctrl_chk #(
   parameter int WIDTH = 4
) (
   input logic                     clk,
   input logic                     rst,
   input logic [WIDTH-1:0]         dout,
   input logic                     dout_valid,
   input logic                     dout_ready,
   input logic                     busy,
   input logic [$clog2(WIDTH)-1:0] bit_cnt
);
   localparam int CNT_W = $clog2(WIDTH);

   a_hold_word : assert property (@(posedge clk) disable iff (rst)
      (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout)));

   a_idle_cnt : assert property (@(posedge clk) disable iff (rst)
      !busy |-> (bit_cnt == CNT_W'(0)));

   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      bit_cnt <= CNT_W'(WIDTH - 1));
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: MSB-first and LSB-first instances share one stimulus.
module tb_sipo_rx_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, abort = 1'b0, sin = 1'b0, sin_valid = 1'b0, dout_ready = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   sipo_rx_ctrl_if #(.WIDTH(4)) if0 ();
   sipo_rx_ctrl_if #(.WIDTH(4)) if1 ();

   assign if0.start = start;      assign if1.start = start;
   assign if0.abort = abort;      assign if1.abort = abort;
   assign if0.sin = sin;          assign if1.sin = sin;
   assign if0.sin_valid = sin_valid;   assign if1.sin_valid = sin_valid;
   assign if0.dout_ready = dout_ready; assign if1.dout_ready = dout_ready;

   sipo_rx_ctrl #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(if0.slave));
   sipo_rx_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(if1.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 3; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] w;
      logic [3:0] cnt_exp;

      tick();
      tick();
      check("rst_dout", if0.dout, 32'h0);
      check("rst_dv", if0.dout_valid, 32'h0);
      check("rst_busy", if0.busy, 32'h0);
      check("rst_cnt", if0.bit_cnt, 32'h0);
      check("rst_ovr", if0.overrun, 32'h0);
      rst = 1'b0;
      sin = 1'b1; sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      check("idle_ignores_sin", if0.bit_cnt, 32'h0);
      check("idle_not_busy", if0.busy, 32'h0);

      // Test 1/2: 1,0,1,1 -> MSB-first 1011, LSB-first 1101
      dout_ready = 1'b1;
      pulse_start();
      check("t1_busy", if0.busy, 32'h1);
      check("t1_cnt0", if0.bit_cnt, 32'h0);
      w = 4'b1011;
      cnt_exp = 4'h0;
      for (int i = 3; i >= 0; i--) begin
         send_bit(w[i]);
         cnt_exp = (cnt_exp + 4'h1) & 4'h3;
         check("t1_cnt_seq", if0.bit_cnt, {28'h0, cnt_exp});
         if (i != 0) check("t1_dv_early", if0.dout_valid, 32'h0);
      end
      check("t1_dv", if0.dout_valid, 32'h1);
      check("t1_dout", if0.dout, 32'hB);
      check("t2_dout_lsb", if1.dout, 32'hD);
      tick();
      check("t1_dv_one_cycle", if0.dout_valid, 32'h0);
      check("t1_dout_kept", if0.dout, 32'hB);

      // Test 3: back-pressure overrun
      dout_ready = 1'b0;
      send_word(4'hA);
      check("t3_dv_a", if0.dout_valid, 32'h1);
      check("t3_ovr_a", if0.overrun, 32'h0);
      send_word(4'h5);
      check("t3_dout_held", if0.dout, 32'hA);
      check("t3_ovr", if0.overrun, 32'h1);
      check("t3_dv_held", if0.dout_valid, 32'h1);
      dout_ready = 1'b1;
      tick();
      check("t3_dv_drop", if0.dout_valid, 32'h0);
      check("t3_ovr_sticky", if0.overrun, 32'h1);
      pulse_start();
      check("t3_ovr_clr", if0.overrun, 32'h0);
      check("t3_dout_after_start", if0.dout, 32'hA);

      // Test 4: continuous 0x3, 0xC with ready high
      send_word(4'h3);
      check("t4_dv_3", if0.dout_valid, 32'h1);
      check("t4_dout_3", if0.dout, 32'h3);
      send_word(4'hC);
      check("t4_dv_c", if0.dout_valid, 32'h1);
      check("t4_dout_c", if0.dout, 32'hC);
      check("t4_ovr", if0.overrun, 32'h0);

      // Back-to-back: completion while the pending word transfers
      dout_ready = 1'b0;
      tick();
      check("b2b_pending", if0.dout_valid, 32'h1);
      w = 4'h6;
      for (int i = 3; i >= 0; i--) begin
         dout_ready = (i == 0);
         send_bit(w[i]);
      end
      check("b2b_dv", if0.dout_valid, 32'h1);
      check("b2b_dout", if0.dout, 32'h6);
      check("b2b_ovr", if0.overrun, 32'h0);
      tick();
      check("b2b_drain", if0.dout_valid, 32'h0);

      // Test 5: abort mid-word with a pending word
      dout_ready = 1'b0;
      send_word(4'h9);
      send_bit(1'b1);
      send_bit(1'b1);
      check("t5_cnt2", if0.bit_cnt, 32'h2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_busy", if0.busy, 32'h0);
      check("t5_cnt", if0.bit_cnt, 32'h0);
      check("t5_dv_kept", if0.dout_valid, 32'h1);
      check("t5_dout_kept", if0.dout, 32'h9);
      dout_ready = 1'b1;
      tick();
      check("t5_idle_xfer", if0.dout_valid, 32'h0);
      start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
      tick();
      start = 1'b0; sin_valid = 1'b0;
      check("t5_start_sv_ignored", if0.bit_cnt, 32'h0);
      send_word(4'b0110);
      check("t5_dout", if0.dout, 32'h6);
      check("t5_dout_lsb", if1.dout, 32'h6);
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      check("abort_wins", if0.busy, 32'h0);

      // Test 6: asynchronous reset mid-word with a pending word
      pulse_start();
      dout_ready = 1'b0;
      send_word(4'hF);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("t6_cnt3", if0.bit_cnt, 32'h3);
      #2 rst = 1'b1;
      #1;
      check("t6_dout", if0.dout, 32'h0);
      check("t6_dv", if0.dout_valid, 32'h0);
      check("t6_busy", if0.busy, 32'h0);
      check("t6_cnt", if0.bit_cnt, 32'h0);
      check("t6_lsb_dout", if1.dout, 32'h0);
      tick();
      rst = 1'b0;
      send_bit(1'b1);
      check("t6_no_sample", if0.bit_cnt, 32'h0);
      pulse_start();
      send_word(4'h5);
      check("t6_resume", if0.dout, 32'h5);
      check("t6_resume_lsb", if1.dout, 32'hA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
